// File: rtl/data_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge.
// Holds bus widths, the MMIO region tag, the MMIO register word offsets
// (taken from daddr[7:2]), the COMPARE reset value, the read-source select
// type and a byte-lane merge helper used for every byte-writable register.
package data_bus_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam logic [15:0] DEF_MMIO_BASE_HI = 16'hBFAF;

  // Word offsets inside the MMIO window (byte offsets 0x00..0x10).
  localparam logic [5:0] LED_OFF  = 6'h00;
  localparam logic [5:0] SW_OFF   = 6'h01;
  localparam logic [5:0] CNT_OFF  = 6'h02;
  localparam logic [5:0] CMP_OFF  = 6'h03;
  localparam logic [5:0] STAT_OFF = 6'h04;

  localparam logic [DATA_W-1:0] CMP_RST = 32'hFFFF_FFFF;

  // Which registered source drives dm.
  typedef enum logic {
    SEL_MMIO = 1'b0,
    SEL_RAM  = 1'b1
  } rd_sel_e;

  // Replace the lanes of old_w whose enable is set with the lanes of new_w.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [WE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < WE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_bus_bridge_dmem_ram.sv
// dmem_ram: single-port synchronous data RAM, 2^RAM_AW x 32 bits.
// Ports:
//   clk_i    - clock, rising edge
//   en_i     - access enable
//   we_i     - byte write enables (all zero = read)
//   addr_i   - word address
//   wdata_i  - lane-aligned write data
//   rdata_o  - registered read data, updated only on read accesses
// Contents are not reset.
module dmem_ram
  import data_bus_bridge_pkg::*;
#(
  parameter int RAM_AW = 12
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [WE_W-1:0]   we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**RAM_AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < WE_W; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      // Output holds across writes and idle cycles so dm stays stable.
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: decodes CPU data-memory accesses to internal RAM, a small
// MMIO register file (LED, SWITCH, COUNT, COMPARE, STATUS) or unmapped space,
// and returns read data one cycle after the request.
// Ports:
//   cpu_clk_50M - clock; cpu_rst - asynchronous active-high reset
//   daddr/dce/we/din - access from the MEM stage (we==0 with dce=1 is a read)
//   dm          - read data, valid the cycle after a read, held otherwise
//   sw_i        - asynchronous switches (2-flop synchronised)
//   led_o       - LED register; timer_irq - sticky timer match flag
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int          RAM_AW       = 12,
  parameter logic [15:0] MMIO_BASE_HI = DEF_MMIO_BASE_HI,
  parameter int          SW_W         = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic [DATA_W-1:0] daddr,
  input  logic              dce,
  input  logic [WE_W-1:0]   we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dm,
  input  logic [SW_W-1:0]   sw_i,
  output logic [SW_W-1:0]   led_o,
  output logic              timer_irq
);

  logic              is_mmio, wr, rd, mmio_wr, ram_en;
  logic [5:0]        off;
  logic [DATA_W-1:0] ram_rdata;

  logic [SW_W-1:0]   led_q, led_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] mmio_rd_q, mmio_rd_d;
  rd_sel_e           sel_q;
  logic [DATA_W-1:0] led_merge;

  assign is_mmio = (daddr[31:16] == MMIO_BASE_HI);
  assign off     = daddr[7:2];
  assign wr      = dce && (we != '0);
  assign rd      = dce && (we == '0);
  assign mmio_wr = wr && is_mmio;
  // Keep a write that overlaps reset out of the (unreset) RAM array.
  assign ram_en  = dce && !is_mmio && !cpu_rst;

  // Bits outside the decoded fields only alias.
  logic unused_bits;
  assign unused_bits = ^{daddr[1:0], daddr[15:8], led_merge[DATA_W-1:SW_W]};

  dmem_ram #(
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk_i   (cpu_clk_50M),
    .en_i    (ram_en),
    .we_i    (we),
    .addr_i  (daddr[RAM_AW+1:2]),
    .wdata_i (din),
    .rdata_o (ram_rdata)
  );

  assign led_merge = byte_merge({{(DATA_W-SW_W){1'b0}}, led_q}, din, we);

  always_comb begin
    led_d  = led_q;
    cmp_d  = cmp_q;
    // A COUNT write replaces the increment, merged against the current value.
    cnt_d  = cnt_q + 32'd1;
    flag_d = flag_q;
    if (mmio_wr) begin
      case (off)
        LED_OFF:  led_d = led_merge[SW_W-1:0];
        CNT_OFF:  cnt_d = byte_merge(cnt_q, din, we);
        CMP_OFF:  cmp_d = byte_merge(cmp_q, din, we);
        STAT_OFF: if (we[0] && din[0]) flag_d = 1'b0;
        default:  ;
      endcase
    end
    // Match is tested after the clear so that set wins on the same cycle.
    if (cnt_q == cmp_q) flag_d = 1'b1;
  end

  always_comb begin
    mmio_rd_d = '0;
    case (off)
      LED_OFF:  mmio_rd_d = {{(DATA_W-SW_W){1'b0}}, led_q};
      SW_OFF:   mmio_rd_d = {{(DATA_W-SW_W){1'b0}}, sw_sync_q};
      CNT_OFF:  mmio_rd_d = cnt_q;
      CMP_OFF:  mmio_rd_d = cmp_q;
      STAT_OFF: mmio_rd_d = {{(DATA_W-1){1'b0}}, flag_q};
      default:  mmio_rd_d = '0;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
      cmp_q     <= CMP_RST;
      flag_q    <= 1'b0;
      mmio_rd_q <= '0;
      sel_q     <= SEL_MMIO;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      flag_q    <= flag_d;
      if (rd) begin
        mmio_rd_q <= mmio_rd_d;
        sel_q     <= is_mmio ? SEL_MMIO : SEL_RAM;
      end
    end
  end

  // Reset selects the cleared MMIO word, so dm drops to 0 without a clock.
  assign dm        = (sel_q == SEL_RAM) ? ram_rdata : mmio_rd_q;
  assign led_o     = led_q;
  assign timer_irq = flag_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic [31:0] daddr;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dm;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        timer_irq;

  data_bus_bridge #(
    .RAM_AW       (12),
    .MMIO_BASE_HI (16'hBFAF),
    .SW_W         (16)
  ) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .daddr       (daddr),
    .dce         (dce),
    .we          (we),
    .din         (din),
    .dm          (dm),
    .sw_i        (sw_i),
    .led_o       (led_o),
    .timer_irq   (timer_irq)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  localparam logic [31:0] A_LED  = 32'hBFAF_0000;
  localparam logic [31:0] A_SW   = 32'hBFAF_0004;
  localparam logic [31:0] A_CNT  = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP  = 32'hBFAF_000C;
  localparam logic [31:0] A_STAT = 32'hBFAF_0010;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  logic        rd_pend;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // A read accepted at an edge must show up on dm right after that edge.
  always @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) rd_pend <= 1'b0;
    else         rd_pend <= dce && (we == 4'h0);
  end

  always @(negedge cpu_clk_50M) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'h1, 32'h0);
      end else begin
        exp_w = exp_q.pop_front();
        check("rd_data", dm, exp_w);
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge cpu_clk_50M);
    dce   = 1'b1;
    daddr = a;
    we    = w;
    din   = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    @(negedge cpu_clk_50M);
    exp_q.push_back(e);
    dce   = 1'b1;
    daddr = a;
    we    = 4'h0;
    din   = 32'h0;
  endtask

  task automatic idle();
    @(negedge cpu_clk_50M);
    dce = 1'b0;
    we  = 4'h0;
  endtask

  initial begin
    cpu_rst = 1'b1;
    dce     = 1'b0;
    daddr   = 32'h0;
    we      = 4'h0;
    din     = 32'h0;
    sw_i    = 16'h1234;

    tbl[0]  = '{32'h0000_0100, 4'hF, 32'h1122_3344, 32'h0};
    tbl[1]  = '{32'h0000_0100, 4'h8, 32'hAA00_0000, 32'h0};
    tbl[2]  = '{32'h0000_0100, 4'h0, 32'h0,         32'hAA22_3344};
    tbl[3]  = '{32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[4]  = '{32'h0000_4004, 4'h0, 32'h0,         32'hDEAD_BEEF};
    tbl[5]  = '{A_LED,         4'hF, 32'hFFFF_A5A5, 32'h0};
    tbl[6]  = '{A_SW,          4'h0, 32'h0,         32'h0000_1234};
    tbl[7]  = '{32'hBFAF_0020, 4'h0, 32'h0,         32'h0};
    tbl[8]  = '{A_LED,         4'h0, 32'h0,         32'h0000_A5A5};
    tbl[9]  = '{A_SW,          4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{A_SW,          4'h0, 32'h0,         32'h0000_1234};
    tbl[11] = '{32'h0000_0100, 4'h0, 32'h0,         32'hAA22_3344};

    #35;
    check("rst_dm", dm, 32'h0);
    check("rst_led", {16'h0, led_o}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we == 4'h0) rd(tbl[i].addr, tbl[i].exp);
      else                   access(tbl[i].addr, tbl[i].we, tbl[i].din);
    end
    idle();
    idle();
    idle();
    check("dm_hold", dm, 32'hAA22_3344);
    check("led_o", {16'h0, led_o}, 32'h0000_A5A5);

    // Timer match: COUNT reaches 10 ten edges after the COUNT write.
    access(A_CNT, 4'hF, 32'd0);
    access(A_CMP, 4'hF, 32'd10);
    for (int k = 0; k < 10; k++) idle();
    check("irq_before_match", {31'h0, timer_irq}, 32'h0);
    idle();
    check("irq_on_match", {31'h0, timer_irq}, 32'h1);
    for (int k = 0; k < 5; k++) idle();
    check("irq_sticky", {31'h0, timer_irq}, 32'h1);

    access(A_STAT, 4'hF, 32'h1);
    idle();
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);

    // Clear coinciding with a match: set wins.
    access(A_CMP, 4'hF, 32'd200);
    access(A_CNT, 4'hF, 32'd200);
    access(A_STAT, 4'hF, 32'h1);
    idle();
    check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    idle();
    check("irq_set_wins_hold", {31'h0, timer_irq}, 32'h1);

    // Wrap: FFFFFFFE -> FFFFFFFF -> 0, sampled by a read three edges later.
    access(A_CNT, 4'hF, 32'hFFFF_FFFE);
    idle();
    idle();
    rd(A_CNT, 32'h0000_0000);

    // Byte write on COUNT=0x1FF merges against the current value.
    access(A_CNT, 4'hF, 32'h0000_01FE);
    idle();
    access(A_CNT, 4'h1, 32'h0);
    rd(A_CNT, 32'h0000_0100);
    rd(A_STAT, 32'h1);
    idle();
    idle();

    // Asynchronous reset during a pending read.
    rd(32'h0000_0100, 32'hAA22_3344);
    idle();
    check("dm_before_rst", dm, 32'hAA22_3344);
    @(negedge cpu_clk_50M);
    dce   = 1'b1;
    daddr = 32'h0000_0004;
    we    = 4'h0;
    #4 cpu_rst = 1'b1;
    #1;
    check("async_dm", dm, 32'h0);
    check("async_led", {16'h0, led_o}, 32'h0);
    check("async_irq", {31'h0, timer_irq}, 32'h0);
    dce = 1'b0;
    @(negedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    rd(A_CMP, 32'hFFFF_FFFF);
    rd(A_LED, 32'h0);
    idle();
    idle();
    idle();
    check("sb_drain", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
